// File: rtl/fmcropping_if.sv
// Valid/ready stream bundle used for both the input and the output side of fmcropping.
interface fmcropping_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 tvalid;
  logic                 tready;
  logic [DATA_BITS-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fmcropping.sv
// Feature-map cropping: forwards only beats whose pixel lies inside the configured
// window; all other beats are consumed and discarded. Output uses a two-entry skid buffer.
module fmcropping #(
  parameter int unsigned XCOUNTER_BITS = 4,
  parameter int unsigned YCOUNTER_BITS = 4,
  parameter int unsigned NUM_CHANNELS  = 1,
  parameter int unsigned SIMD          = 1,
  parameter int unsigned ELEM_BITS     = 8,
  parameter int unsigned INIT_XON      = 1,
  parameter int unsigned INIT_XOFF     = 3,
  parameter int unsigned INIT_XEND     = 3,
  parameter int unsigned INIT_YON      = 1,
  parameter int unsigned INIT_YOFF     = 3,
  parameter int unsigned INIT_YEND     = 3
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         we,
  input  logic [2:0]   wa,
  input  logic [31:0]  wd,
  fmcropping_if.slave  s_axis,
  fmcropping_if.master m_axis
);
  localparam int unsigned STREAM_BITS = 8 * ((SIMD * ELEM_BITS + 7) / 8);
  localparam int unsigned SIMD_SAFE   = (SIMD == 0) ? 1 : SIMD;
  localparam int unsigned SF          = (NUM_CHANNELS / SIMD_SAFE == 0) ? 1 : NUM_CHANNELS / SIMD_SAFE;
  localparam int unsigned SCNT_BITS   = (SF > 1) ? $clog2(SF) : 1;

  if (NUM_CHANNELS < 1 || SIMD < 1 || (NUM_CHANNELS % SIMD_SAFE) != 0) begin : g_bad_cfg
    $error("fmcropping: NUM_CHANNELS must be >= 1 and a multiple of SIMD");
  end

  logic [XCOUNTER_BITS-1:0] x_on, x_off, x_end, x_cnt;
  logic [YCOUNTER_BITS-1:0] y_on, y_off, y_end, y_cnt;
  logic [SCNT_BITS-1:0]     s_cnt;

  logic                   a_vld, b_vld;
  logic [STREAM_BITS-1:0] a_data, b_data;
  logic                   keep, in_hs, b_free;
  logic                   unused_wd;

  assign unused_wd = ^wd;

  // Configuration registers; reserved addresses leave every register untouched.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      x_on  <= XCOUNTER_BITS'(INIT_XON);
      x_off <= XCOUNTER_BITS'(INIT_XOFF);
      x_end <= XCOUNTER_BITS'(INIT_XEND);
      y_on  <= YCOUNTER_BITS'(INIT_YON);
      y_off <= YCOUNTER_BITS'(INIT_YOFF);
      y_end <= YCOUNTER_BITS'(INIT_YEND);
    end else if (we) begin
      case (wa)
        3'd0:    x_on  <= wd[XCOUNTER_BITS-1:0];
        3'd1:    x_off <= wd[XCOUNTER_BITS-1:0];
        3'd2:    x_end <= wd[XCOUNTER_BITS-1:0];
        3'd4:    y_on  <= wd[YCOUNTER_BITS-1:0];
        3'd5:    y_off <= wd[YCOUNTER_BITS-1:0];
        3'd6:    y_end <= wd[YCOUNTER_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst_n && we)
      assert (wa[1:0] != 2'b11)
      else $error("fmcropping: configuration write to reserved address %0d", wa);
  end

  assign s_axis.tready = ap_rst_n && !a_vld;
  assign in_hs         = s_axis.tvalid && s_axis.tready;
  assign b_free        = !b_vld || m_axis.tready;
  assign keep          = (x_on <= x_cnt) && (x_cnt < x_off) &&
                         (y_on <= y_cnt) && (y_cnt < y_off);

  // Nested beat/column/row counters, advanced only by accepted input beats.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s_cnt <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_hs) begin
      if (s_cnt == SCNT_BITS'(SF - 1)) begin
        s_cnt <= '0;
        if (x_cnt == x_end) begin
          x_cnt <= '0;
          if (y_cnt == y_end) y_cnt <= '0;
          else                y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end else begin
        s_cnt <= s_cnt + 1'b1;
      end
    end
  end

  // B drains on handshake; A refills B before any new beat, since A full blocks input.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (b_vld && m_axis.tready) b_vld <= 1'b0;
      if (a_vld && b_free) begin
        b_data <= a_data;
        b_vld  <= 1'b1;
        a_vld  <= 1'b0;
      end else if (in_hs && keep) begin
        if (b_free) begin
          b_data <= s_axis.tdata;
          b_vld  <= 1'b1;
        end else begin
          a_data <= s_axis.tdata;
          a_vld  <= 1'b1;
        end
      end
    end
  end

  assign m_axis.tvalid = b_vld;
  assign m_axis.tdata  = b_data;
endmodule

// File: doc/fmcropping.md
# fmcropping

Feature-map cropping block: consumes a padded or oversized feature-map stream and forwards only the pixels inside a runtime-configurable rectangular window. Every beat outside the window is discarded. It is the inverse of the padding block and sits in the same AXI-Stream dataflow pipeline. It is used wherever a border must be stripped, for example after a padded convolution or ahead of a stride-aligned consumer. Window geometry uses the same runtime configuration port and register map as the padding block.

## Interface
- XCOUNTER_BITS, none: width of column counter and X configuration registers.
- YCOUNTER_BITS, none: width of row counter and Y configuration registers.
- NUM_CHANNELS, none: channels per pixel; must be ≥1 and a multiple of SIMD.
- SIMD, none: channels per stream beat. SF = NUM_CHANNELS/SIMD beats per pixel.
- ELEM_BITS, none: bits per channel element.
- INIT_XON / INIT_XOFF / INIT_XEND, none: reset values of the first kept column, the first dropped column after the window, and the last input column index.
- INIT_YON / INIT_YOFF / INIT_YEND, none: same as the X values, for rows.
- STREAM_BITS (localparam): 8*ceil(SIMD*ELEM_BITS/8).
- ap_clk  in  1  sole clock; all logic on its rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- we  in  1  configuration write enable.
- wa  in  3  configuration address.
- wd  in  32  configuration data, truncated to the target register width.
- s_axis_tready  out  1  input ready.
- s_axis_tvalid  in  1  input valid.
- s_axis_tdata  in  STREAM_BITS  input beat.
- m_axis_tready  in  1  output ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  STREAM_BITS  output beat.

## Operation
- Configuration registers, written when we=1:
  - wa 0 → XOn, 1 → XOff, 2 → XEnd.
  - wa 4 → YOn, 5 → YOff, 6 → YEnd.
  - wa 3/7: no register changes; simulation assertion error.
  - All six registers load their INIT_* values on reset.
- Writes take effect the next cycle. They are only guaranteed meaningful between frames; a mid-frame write changes the window of the remaining beats immediately.
- Nested counters advance only on an input handshake (s_axis_tvalid && s_axis_tready):
  - SCount: 0..SF-1.
  - On SCount wrap, XCount: 0..XEnd.
  - On XCount wrap, YCount: 0..YEnd.
  - On YCount wrap, the frame ends and all counters return to 0.
- keep = (XOn ≤ XCount < XOff) && (YOn ≤ YCount < YOff), evaluated on the current counter values for the beat being accepted. All SF beats of a pixel share the same keep value.
- Kept beats are forwarded in order with data unmodified. Dropped beats are accepted and discarded; they produce no output.
- Output path is a two-register skid buffer: B drives m_axis_*, A is the skid register.
  - s_axis_tready = !A.vld; forced 0 while ap_rst_n is low.
  - Kept beat accepted while B is empty or m_axis_tready=1: the beat loads into B.
  - Kept beat accepted otherwise: the beat loads into A.
  - When A.vld and B frees (m_axis_tready=1 or B empty): A moves to B and A empties.
- While A is full, every input stalls, including beats that would be dropped. Order is preserved strictly.
- Degenerate windows (XOn ≥ XOff or YOn ≥ YOff): the whole frame is consumed and nothing is output.
- XOff > XEnd+1 keeps through the last column.
- Elaboration error if NUM_CHANNELS < 1 or NUM_CHANNELS % SIMD ≠ 0.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata don't-care, s_axis_tready=0 while reset is asserted and 1 on the first cycle after release. Counters are 0.
- Latency: a kept beat accepted in cycle n appears on m_axis in cycle n+1.
- Throughput: 1 beat/cycle sustained when m_axis_tready=1.
- Dropped beats are consumed at 1 beat/cycle whenever A is empty, independent of m_axis_tready.
- Backpressure: after m_axis_tready falls, at most one further kept beat is absorbed into A; then s_axis_tready=0.
- s_axis_tready returns to 1 the cycle after A drains.
- A→B transfer and new input never coincide, since tready=0 while A is valid.
- m_axis_tvalid, once high, holds with stable data until the m_axis handshake.
- Reset asserted mid-frame empties A and B immediately (asynchronous), zeroes the counters, and reloads the INIT configuration. The next accepted beat is treated as pixel (0,0), SCount 0.

## Test plan
- Defaults XEND=YEND=3, XON=YON=1, XOFF=YOFF=3, SF=1; tdata 0..31 (two frames), m_axis_tready=1 → output exactly 5,6,9,10,21,22,25,26, each 1 cycle after its input. s_axis_tready is never low.
- NUM_CHANNELS=4, SIMD=2 (SF=2), same window, tdata 0..31 as one frame → output 10,11,12,13,18,19,20,21 in order.
- First test with m_axis_tready held low for cycles 6..12 → s_axis_tready falls after beat 6 is absorbed. Output is still 5,6,9,10 with no loss or duplicates. tready recovers the cycle after A drains.
- Between frames, write we=1 wa=1 wd=4 and wa=5 wd=4 → the next 16-beat frame outputs 5,6,7,9,10,11,13,14,15. A write to wa=3 raises an assertion error and leaves the window unchanged.
- XON=XOFF=2 → a 16-beat frame is consumed in 16 cycles with m_axis_tvalid=0 throughout.
- Assert ap_rst_n=0 after beat 7 of a frame with B full → m_axis_tvalid goes to 0 without waiting for a clock edge. The next frame 0..15 outputs 5,6,9,10.
